// File: rtl/score_board_if.sv
// Bus between process control / game logic and the high-score table.
// The slave modport is the score_board side; the master modport drives submissions and reads.
interface score_board_if #(
  parameter int ENTRIES = 4,
  parameter int SCORE_W = 32,
  parameter int ID_W    = 16
) ();
  localparam int IDX_W = $clog2(ENTRIES);

  logic               submit;
  logic [SCORE_W-1:0] submit_score;
  logic [ID_W-1:0]    submit_id;
  logic               clear;
  logic [IDX_W-1:0]   rd_index;
  logic [SCORE_W-1:0] rd_score;
  logic [ID_W-1:0]    rd_id;
  logic               rd_valid;
  logic [SCORE_W-1:0] top_score;
  logic               busy;
  logic               ack;
  logic [IDX_W:0]     rank;

  modport slave (
    input  submit, submit_score, submit_id, clear, rd_index,
    output rd_score, rd_id, rd_valid, top_score, busy, ack, rank
  );

  modport master (
    output submit, submit_score, submit_id, clear, rd_index,
    input  rd_score, rd_id, rd_valid, top_score, busy, ack, rank
  );
endinterface

// File: rtl/score_board.sv
// Top-N high-score table kept sorted descending; inserts one result at a time
// by scanning for the slot, shifting lower entries down, then writing.
module score_board #(
  parameter int ENTRIES = 4,
  parameter int SCORE_W = 32,
  parameter int ID_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  score_board_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ENTRIES - 1);
  localparam logic [IDX_W:0]   RANK_NONE = (IDX_W + 1)'(ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPARE = 3'd1,
    S_SHIFT   = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SCORE_W-1:0] r_score [ENTRIES];
  logic [ID_W-1:0]    r_id    [ENTRIES];
  logic [ENTRIES-1:0] r_valid;

  logic [SCORE_W-1:0] r_new_score;
  logic [ID_W-1:0]    r_new_id;
  logic [IDX_W-1:0]   r_i;
  logic [IDX_W-1:0]   r_j;
  logic [IDX_W-1:0]   r_pos;
  logic [IDX_W:0]     r_rank;

  logic             w_latch;
  logic             w_inc_i;
  logic             w_set_pos;
  logic             w_shift;
  logic             w_write;
  logic             w_rank_none;
  logic             w_place;
  logic [IDX_W-1:0] w_j_prev;

  // Zero never wins, even against an empty slot, so it always runs to "not placed".
  assign w_place  = (r_new_score != {SCORE_W{1'b0}}) &&
                    (!r_valid[r_i] || (r_new_score > r_score[r_i]));
  assign w_j_prev = r_j - IDX_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_inc_i     = 1'b0;
    w_set_pos   = 1'b0;
    w_shift     = 1'b0;
    w_write     = 1'b0;
    w_rank_none = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.submit) begin
          w_latch     = 1'b1;
          w_state_nxt = S_COMPARE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_COMPARE: begin
        if (w_place) begin
          w_set_pos   = 1'b1;
          w_state_nxt = (r_i == LAST_IDX) ? S_WRITE : S_SHIFT;
        end else if (r_i == LAST_IDX) begin
          w_rank_none = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_inc_i = 1'b1;
        end
      end
      S_SHIFT: begin
        // Leave on the cycle that performs the last move so no idle shift cycle is spent.
        w_shift = 1'b1;
        if (w_j_prev == r_pos) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_WRITE: begin
        w_write     = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (bus.clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= {ENTRIES{1'b0}};
      r_rank      <= RANK_NONE;
      r_new_score <= {SCORE_W{1'b0}};
      r_new_id    <= {ID_W{1'b0}};
      r_i         <= {IDX_W{1'b0}};
      r_j         <= {IDX_W{1'b0}};
      r_pos       <= {IDX_W{1'b0}};
      for (int k = 0; k < ENTRIES; k++) begin
        r_score[k] <= {SCORE_W{1'b0}};
        r_id[k]    <= {ID_W{1'b0}};
      end
    end else if (bus.clear) begin
      r_valid <= {ENTRIES{1'b0}};
    end else begin
      if (w_latch) begin
        r_new_score <= bus.submit_score;
        r_new_id    <= bus.submit_id;
        r_i         <= {IDX_W{1'b0}};
      end
      if (w_inc_i) begin
        r_i <= r_i + IDX_W'(1);
      end
      if (w_set_pos) begin
        r_pos <= r_i;
        r_j   <= LAST_IDX;
      end
      if (w_shift) begin
        r_score[r_j] <= r_score[w_j_prev];
        r_id[r_j]    <= r_id[w_j_prev];
        r_valid[r_j] <= r_valid[w_j_prev];
        r_j          <= w_j_prev;
      end
      if (w_write) begin
        r_score[r_pos] <= r_new_score;
        r_id[r_pos]    <= r_new_id;
        r_valid[r_pos] <= 1'b1;
        r_rank         <= {1'b0, r_pos};
      end
      if (w_rank_none) begin
        r_rank <= RANK_NONE;
      end
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.ack       = (r_state == S_DONE) && !bus.clear && !rst;
  assign bus.rank      = r_rank;
  assign bus.rd_valid  = r_valid[bus.rd_index];
  assign bus.rd_score  = r_valid[bus.rd_index] ? r_score[bus.rd_index] : {SCORE_W{1'b0}};
  assign bus.rd_id     = r_valid[bus.rd_index] ? r_id[bus.rd_index] : {ID_W{1'b0}};
  assign bus.top_score = r_valid[0] ? r_score[0] : {SCORE_W{1'b0}};
endmodule

// File: tb/tb_score_board.sv
// Directed self-checking bench for score_board (ENTRIES=4): insertion order, ties,
// full-table eviction, non-placement, busy/ack timing, clear and reset aborts.
module tb_score_board;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  score_board_if #(.ENTRIES(4), .SCORE_W(32), .ID_W(16)) bus ();

  score_board #(.ENTRIES(4), .SCORE_W(32), .ID_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Pulses one submit, then watches a fixed 12-cycle window; optionally pulses a
  // second submit at cycle extra_k and scrambles submit_score after sampling.
  task automatic run_submit(input logic [31:0] sc, input logic [15:0] id,
                            input int extra_k, input logic [31:0] extra_sc,
                            output int ack_cyc, output int n_acks,
                            output bit busy_ok, output bit idle_after);
    @(negedge clk);
    bus.submit       = 1'b1;
    bus.submit_score = sc;
    bus.submit_id    = id;
    ack_cyc    = -1;
    n_acks     = 0;
    busy_ok    = 1'b1;
    idle_after = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.submit       = 1'b0;
      bus.submit_score = 32'hFFFF_FFFF;
      bus.submit_id    = 16'hEEEE;
      if (bus.ack) begin
        n_acks++;
        if (ack_cyc < 0) ack_cyc = k;
      end
      if ((ack_cyc < 0 || ack_cyc == k) && !bus.busy) busy_ok = 1'b0;
      if (ack_cyc > 0 && k == ack_cyc + 1) idle_after = !bus.busy && !bus.ack;
      if (k == extra_k) begin
        bus.submit       = 1'b1;
        bus.submit_score = extra_sc;
        bus.submit_id    = 16'hFFFF;
      end
    end
    bus.submit = 1'b0;
  endtask

  task automatic rd_slot(input logic [1:0] idx, output logic [31:0] sc,
                         output logic [15:0] id, output logic v);
    bus.rd_index = idx;
    #1;
    sc = bus.rd_score;
    id = bus.rd_id;
    v  = bus.rd_valid;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] sc;
    logic [15:0] id;
    logic        v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd_slot(2'(k), sc, id, v);
      checks++;
      if (v !== 1'b0 || sc !== 32'd0 || id !== 16'd0) begin
        errors++;
        $display("FAIL reset_slot%0d got v=%b sc=%0d id=%h want v=0 sc=0 id=0", k, v, sc, id);
      end
    end
    checks++;
    if (bus.top_score !== 32'd0 || bus.busy !== 1'b0 || bus.ack !== 1'b0 || bus.rank !== 3'd4) begin
      errors++;
      $display("FAIL reset_ctrl got top=%0d busy=%b ack=%b rank=%0d want 0 0 0 4",
               bus.top_score, bus.busy, bus.ack, bus.rank);
    end
  endtask

  task automatic test_first_insert();
    int ac, na;
    bit bo, ia;
    logic [31:0] sc;
    logic [15:0] id;
    logic        v;
    run_submit(32'd100, 16'hA001, 0, 32'd0, ac, na, bo, ia);
    checks++;
    if (ac !== 6 || na !== 1 || !bo || !ia) begin
      errors++;
      $display("FAIL first_timing got ack_cyc=%0d acks=%0d busy_ok=%0d idle_after=%0d want 6 1 1 1", ac, na, bo, ia);
    end
    checks++;
    if (bus.rank !== 3'd0 || bus.top_score !== 32'd100) begin
      errors++;
      $display("FAIL first_rank got rank=%0d top=%0d want 0 100", bus.rank, bus.top_score);
    end
    rd_slot(2'd0, sc, id, v);
    checks++;
    if (v !== 1'b1 || id !== 16'hA001) begin
      errors++;
      $display("FAIL first_slot0 got v=%b id=%h want 1 a001", v, id);
    end
    rd_slot(2'd1, sc, id, v);
    checks++;
    if (v !== 1'b0 || sc !== 32'd0) begin
      errors++;
      $display("FAIL first_slot1 got v=%b sc=%0d want 0 0", v, sc);
    end
  endtask

  task automatic test_fill();
    logic [31:0] sub_sc [3] = '{32'd50, 32'd200, 32'd150};
    logic [15:0] sub_id [3] = '{16'h0050, 16'h0200, 16'h0150};
    logic [2:0]  exp_rk [3] = '{3'd1, 3'd0, 3'd1};
    logic [31:0] exp_sc [4] = '{32'd200, 32'd150, 32'd100, 32'd50};
    logic [15:0] exp_id [4] = '{16'h0200, 16'h0150, 16'hA001, 16'h0050};
    int ac, na;
    bit bo, ia;
    logic [31:0] sc;
    logic [15:0] id;
    logic        v;
    for (int n = 0; n < 3; n++) begin
      run_submit(sub_sc[n], sub_id[n], 0, 32'd0, ac, na, bo, ia);
      checks++;
      if (ac !== 6 || na !== 1 || bus.rank !== exp_rk[n]) begin
        errors++;
        $display("FAIL fill_%0d got ack_cyc=%0d acks=%0d rank=%0d want 6 1 %0d", n, ac, na, bus.rank, exp_rk[n]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      rd_slot(2'(k), sc, id, v);
      checks++;
      if (v !== 1'b1 || sc !== exp_sc[k] || id !== exp_id[k]) begin
        errors++;
        $display("FAIL fill_slot%0d got v=%b sc=%0d id=%h want 1 %0d %h", k, v, sc, id, exp_sc[k], exp_id[k]);
      end
    end
  endtask

  task automatic test_tie_full();
    logic [31:0] exp_sc [4] = '{32'd200, 32'd150, 32'd150, 32'd100};
    logic [15:0] exp_id [4] = '{16'h0200, 16'h0150, 16'hB002, 16'hA001};
    int ac, na;
    bit bo, ia;
    logic [31:0] sc;
    logic [15:0] id;
    logic        v;
    run_submit(32'd150, 16'hB002, 0, 32'd0, ac, na, bo, ia);
    checks++;
    if (ac !== 6 || na !== 1 || bus.rank !== 3'd2) begin
      errors++;
      $display("FAIL tie_rank got ack_cyc=%0d acks=%0d rank=%0d want 6 1 2", ac, na, bus.rank);
    end
    for (int k = 0; k < 4; k++) begin
      rd_slot(2'(k), sc, id, v);
      checks++;
      if (v !== 1'b1 || sc !== exp_sc[k] || id !== exp_id[k]) begin
        errors++;
        $display("FAIL tie_slot%0d got v=%b sc=%0d id=%h want 1 %0d %h", k, v, sc, id, exp_sc[k], exp_id[k]);
      end
    end
  endtask

  task automatic test_zero_score();
    int ac, na;
    bit bo, ia;
    logic [31:0] sc;
    logic [15:0] id;
    logic        v;
    pulse_clear();
    rd_slot(2'd0, sc, id, v);
    checks++;
    if (v !== 1'b0 || bus.top_score !== 32'd0 || bus.rank !== 3'd2 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle got v0=%b top=%0d rank=%0d busy=%b want 0 0 2 0", v, bus.top_score, bus.rank, bus.busy);
    end
    run_submit(32'd0, 16'h0ABC, 0, 32'd0, ac, na, bo, ia);
    rd_slot(2'd0, sc, id, v);
    checks++;
    if (ac !== 5 || na !== 1 || bus.rank !== 3'd4 || v !== 1'b0 || !bo || !ia) begin
      errors++;
      $display("FAIL zero_score got ack_cyc=%0d acks=%0d rank=%0d v0=%b want 5 1 4 0", ac, na, bus.rank, v);
    end
  endtask

  task automatic test_not_placed();
    logic [31:0] fill_sc [4] = '{32'd200, 32'd150, 32'd100, 32'd50};
    int ac, na;
    bit bo, ia;
    logic [31:0] sc;
    logic [15:0] id;
    logic        v;
    for (int n = 0; n < 4; n++) begin
      run_submit(fill_sc[n], 16'(n + 1), 0, 32'd0, ac, na, bo, ia);
    end
    checks++;
    if (bus.rank !== 3'd3) begin
      errors++;
      $display("FAIL refill_rank got %0d want 3", bus.rank);
    end
    run_submit(32'd10, 16'h0010, 2, 32'd999, ac, na, bo, ia);
    checks++;
    if (ac !== 5 || na !== 1 || bus.rank !== 3'd4 || !bo || !ia) begin
      errors++;
      $display("FAIL not_placed got ack_cyc=%0d acks=%0d rank=%0d busy_ok=%0d idle_after=%0d want 5 1 4 1 1",
               ac, na, bus.rank, bo, ia);
    end
    for (int k = 0; k < 4; k++) begin
      rd_slot(2'(k), sc, id, v);
      checks++;
      if (v !== 1'b1 || sc !== fill_sc[k] || id !== 16'(k + 1)) begin
        errors++;
        $display("FAIL unchanged_slot%0d got v=%b sc=%0d id=%h want 1 %0d %0d", k, v, sc, id, fill_sc[k], k + 1);
      end
    end
  endtask

  task automatic test_clear_mid();
    int   n_acks = 0;
    logic [31:0] sc;
    logic [15:0] id;
    logic        v;
    logic        any_v = 1'b0;
    @(negedge clk);
    bus.submit       = 1'b1;
    bus.submit_score = 32'd300;
    bus.submit_id    = 16'h0300;
    @(negedge clk);
    bus.submit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre_busy got %b want 1", bus.busy);
    end
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd_slot(2'(k), sc, id, v);
      any_v |= v;
    end
    checks++;
    if (bus.busy !== 1'b0 || any_v !== 1'b0 || bus.top_score !== 32'd0 || bus.rank !== 3'd4) begin
      errors++;
      $display("FAIL clear_mid got busy=%b any_valid=%b top=%0d rank=%0d want 0 0 0 4",
               bus.busy, any_v, bus.top_score, bus.rank);
    end
    repeat (10) begin
      @(negedge clk);
      if (bus.ack) n_acks++;
    end
    checks++;
    if (n_acks !== 0) begin
      errors++;
      $display("FAIL clear_no_ack got %0d acks want 0", n_acks);
    end
  endtask

  task automatic test_rst_mid();
    int ac, na;
    bit bo, ia;
    int n_acks = 0;
    logic [31:0] sc;
    logic [15:0] id;
    logic        v;
    run_submit(32'd5, 16'h0005, 0, 32'd0, ac, na, bo, ia);
    checks++;
    if (ac !== 6 || bus.rank !== 3'd0 || bus.top_score !== 32'd5) begin
      errors++;
      $display("FAIL after_clear_insert got ack_cyc=%0d rank=%0d top=%0d want 6 0 5", ac, bus.rank, bus.top_score);
    end
    @(negedge clk);
    bus.submit       = 1'b1;
    bus.submit_score = 32'd3;
    @(negedge clk);
    bus.submit = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_slot(2'd0, sc, id, v);
    checks++;
    if (bus.busy !== 1'b0 || v !== 1'b0 || bus.rank !== 3'd4 || bus.top_score !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid got busy=%b v0=%b rank=%0d top=%0d want 0 0 4 0", bus.busy, v, bus.rank, bus.top_score);
    end
    repeat (10) begin
      @(negedge clk);
      if (bus.ack) n_acks++;
    end
    checks++;
    if (n_acks !== 0) begin
      errors++;
      $display("FAIL rst_no_ack got %0d acks want 0", n_acks);
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.submit       = 1'b0;
    bus.submit_score = 32'd0;
    bus.submit_id    = 16'd0;
    bus.clear        = 1'b0;
    bus.rd_index     = 2'd0;
    test_reset();
    test_first_insert();
    test_fill();
    test_tie_full();
    test_zero_score();
    test_not_placed();
    test_clear_mid();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/score_board.md
Name: score_board

Overview:
- Holds the top-N high-score table for the game and feeds the score-display mux with the table contents and the current best score.
- Sits downstream of the game module (final score) and the process control (logged-in user id).
- Accepts one finished-game result at a time and inserts it in descending order over several cycles.
- Reports the achieved rank back to process control.

Parameters:
- ENTRIES, 4, number of table slots (power of two, >=2).
- SCORE_W, 32, score width.
- ID_W, 16, user id width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- submit  in  1  one-cycle request to insert a result; sampled only in IDLE.
- submit_score  in  SCORE_W  score to insert, valid with submit.
- submit_id  in  ID_W  user id, valid with submit.
- clear  in  1  one-cycle pulse; wipes the table.
- rd_index  in  log2(ENTRIES)  table slot to read (0 = best).
- rd_score  out  SCORE_W  score at rd_index; 0 if the slot is invalid.
- rd_id  out  ID_W  id at rd_index; 0 if the slot is invalid.
- rd_valid  out  1  slot at rd_index holds an entry.
- top_score  out  SCORE_W  score of slot 0, or 0 if slot 0 is empty.
- busy  out  1  high in any state other than IDLE.
- ack  out  1  one-cycle pulse when a submission completes.
- rank  out  log2(ENTRIES)+1  slot where the last submission was placed; ENTRIES = not placed. Held until the next ack.

Behaviour:
- Only one clock and one reset are used. Reset is synchronous and active-high.
- Storage: per slot a score, id and valid bit. Table is always sorted descending, with valid slots contiguous from 0.
- rd_*, top_score: combinational reads of the registered storage.
- Reset values: all valid=0, state IDLE, busy=0, ack=0, rank=ENTRIES. Therefore rd_valid=0, rd_score=0, rd_id=0, top_score=0.
- FSM states: IDLE, COMPARE, SHIFT, WRITE, DONE.
  - IDLE: on submit, latch score and id, set index i=0, go to COMPARE.
  - COMPARE: one slot per cycle.
    - If !valid[i] or new > score[i]: pos=i, j=ENTRIES-1, go to SHIFT.
    - Else i++. If i reaches ENTRIES: rank=ENTRIES, go to DONE.
  - SHIFT: one slot per cycle. If j>pos: slot[j]<=slot[j-1] (score, id, valid), j--. When j==pos, go to WRITE (no shift cycle when pos=ENTRIES-1).
  - WRITE: slot[pos]<={new score, id, valid=1}; rank=pos; go to DONE.
  - DONE: ack=1 for this cycle only; go to IDLE.
- Ties: the new entry goes below existing equal scores (strict >), so older entries keep precedence.
- Score 0 is never placed: COMPARE treats it as not greater than anything, including invalid slots. It completes with rank=ENTRIES.
- When the table is full and an entry is placed, the old slot ENTRIES-1 is discarded.
- Latency, counted from the clock edge that samples submit:
  - Placed entry: ack is high in cycle ENTRIES+2, regardless of pos. Cycle counts are COMPARE pos+1, SHIFT ENTRIES-1-pos, WRITE 1, DONE 1.
  - Not placed: ack is high in cycle ENTRIES+1.
- submit while busy: ignored, not queued.
- clear: honoured in any state and has priority over everything.
  - All valid<=0; state<=IDLE; no ack; rank unchanged.
  - An in-flight insertion is aborted.
  - submit in the same cycle as clear is dropped.
- rst mid-operation: identical to the reset values above, with no ack.
- submit_score and submit_id are only sampled in IDLE; later changes have no effect.

Test Plan:
- After rst: rd_valid=0 for every rd_index, top_score=0, busy=0, rank=4.
- Empty table, submit 100/id 0xA001: busy in cycles 1..5, ack in cycle 6, rank=0, top_score=100, slot1 rd_valid=0.
- Submit 50, 200, 150 in turn (each after the previous ack): slots hold 200, 150, 100, 50; ranks reported are 1, 0, 1.
- Full table {200,150,100,50}, submit 150/id 0xB002: rank=2; table becomes 200, 150(A), 150(B), 100; 50 discarded.
- Full table, submit 10 (and separately submit 0 on an empty table): ack in cycle 5, rank=4, table unchanged; a second submit pulsed in cycle 2 is ignored.
- Pulse clear during SHIFT: next cycle busy=0, all rd_valid=0, top_score=0, no ack at any later cycle.
